// File: rtl/memoria_principal_ctrl_pkg.sv
// Shared constants and FSM encoding for the main-memory controller.
// ADDR_W/DATA_W are shared with the cache so tag/index/block fields agree.
package memoria_principal_ctrl_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/memoria_array.sv
// Backing store: register array with address-pattern reset contents,
// one write port and one registered read port.
module memoria_array #(
  parameter int unsigned AddrW = 5,
  parameter int unsigned DataW = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= DataW'(i);
      end
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memoria_principal_ctrl.sv
// Main-memory controller: req/done handshake with write priority, fixed access
// latency and saturating read/write statistics counters.
module memoria_principal_ctrl #(
  parameter int unsigned ADDR_W  = memoria_principal_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W  = memoria_principal_ctrl_pkg::DATA_W,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              solicitacao_de_leitura_na_memoria,
  input  logic              solicitacao_de_escrita_na_memoria,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [DATA_W-1:0] dado_escrita,
  output logic [DATA_W-1:0] dado_leitura,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  leituras,
  output logic [CNT_W-1:0]  escritas
);

  import memoria_principal_ctrl_pkg::*;

  localparam logic [3:0] LatCnt = 4'(LATENCY - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              done_q;
  logic              busy_q;
  logic [CNT_W-1:0]  leituras_q;
  logic [CNT_W-1:0]  escritas_q;

  logic commit;
  assign commit = (state_q == StBusy) && (cnt_q == 4'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      leituras_q <= '0;
      escritas_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          // Write wins so a dirty victim reaches memory before the fill.
          if (solicitacao_de_escrita_na_memoria) begin
            op_wr_q <= 1'b1;
            addr_q  <= endereco;
            wdata_q <= dado_escrita;
            cnt_q   <= LatCnt;
            busy_q  <= 1'b1;
            state_q <= StBusy;
          end else if (solicitacao_de_leitura_na_memoria) begin
            op_wr_q <= 1'b0;
            addr_q  <= endereco;
            cnt_q   <= LatCnt;
            busy_q  <= 1'b1;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= StDone;
            done_q  <= 1'b1;
            if (op_wr_q) begin
              if (escritas_q != '1) escritas_q <= escritas_q + 1'b1;
            end else begin
              if (leituras_q != '1) leituras_q <= leituras_q + 1'b1;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  memoria_array #(
    .AddrW(ADDR_W),
    .DataW(DATA_W)
  ) u_array (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .we_i   (commit && op_wr_q),
    .waddr_i(addr_q),
    .wdata_i(wdata_q),
    .re_i   (commit && !op_wr_q),
    .raddr_i(addr_q),
    .rdata_o(dado_leitura)
  );

  assign done     = done_q;
  assign busy     = busy_q;
  assign leituras = leituras_q;
  assign escritas = escritas_q;

endmodule

// File: tb/tb_memoria_principal_ctrl.sv
// Self-checking bench: directed cases plus random traffic against a simple
// array/counter reference model of the main memory.
module tb_memoria_principal_ctrl;

  localparam int unsigned LATENCY = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = 255;

  logic       clock;
  logic       reset_n;
  logic       rd;
  logic       wr;
  logic [4:0] endereco;
  logic [4:0] dado_escrita;
  logic [4:0] dado_leitura;
  logic       done;
  logic       busy;
  logic [7:0] leituras;
  logic [7:0] escritas;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: plain memory image, saturating counts, last fill data.
  logic [4:0] mem_m [32];
  int         lei_m;
  int         esc_m;
  logic [4:0] last_rd_m;

  memoria_principal_ctrl #(
    .ADDR_W (5),
    .DATA_W (5),
    .LATENCY(LATENCY),
    .CNT_W  (CNT_W)
  ) dut (
    .clock                            (clock),
    .reset_n                          (reset_n),
    .solicitacao_de_leitura_na_memoria(rd),
    .solicitacao_de_escrita_na_memoria(wr),
    .endereco                         (endereco),
    .dado_escrita                     (dado_escrita),
    .dado_leitura                     (dado_leitura),
    .done                             (done),
    .busy                             (busy),
    .leituras                         (leituras),
    .escritas                         (escritas)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = 5'(i);
    lei_m     = 0;
    esc_m     = 0;
    last_rd_m = '0;
  endtask

  // Called at a negedge with the request already driven; returns at a negedge
  // one cycle after the done pulse, with the completed request dropped.
  task automatic wait_done(input bit is_wr, input logic [4:0] a, input logic [4:0] d,
                           input bit scramble);
    int n    = 0;
    bit seen = 0;
    while (!seen && n < 40) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (n == 1) begin
        chk("busy_in_flight", 32'(busy), 32'd1);
        if (scramble) begin
          endereco     = ~a;
          dado_escrita = ~d;
        end
      end
      if (done === 1'b1) seen = 1;
    end
    chk("done_latency", 32'(n), 32'(LATENCY + 1));
    if (is_wr) begin
      mem_m[a] = d;
      if (esc_m != CNT_MAX) esc_m++;
      wr = 1'b0;
      chk("read_data_held", 32'(dado_leitura), 32'(last_rd_m));
    end else begin
      last_rd_m = mem_m[a];
      if (lei_m != CNT_MAX) lei_m++;
      rd = 1'b0;
      chk("read_data", 32'(dado_leitura), 32'(last_rd_m));
    end
    @(posedge clock);
    @(negedge clock);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
    chk("leituras", 32'(leituras), 32'(lei_m));
    chk("escritas", 32'(escritas), 32'(esc_m));
  endtask

  task automatic do_read(input logic [4:0] a);
    endereco = a;
    rd       = 1'b1;
    wait_done(1'b0, a, 5'd0, 1'b0);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [4:0] d);
    endereco     = a;
    dado_escrita = d;
    wr           = 1'b1;
    wait_done(1'b1, a, d, 1'b0);
  endtask

  initial begin
    bit         saw_done;
    logic [4:0] ra;
    logic [4:0] rdat;

    rd           = 1'b0;
    wr           = 1'b0;
    endereco     = '0;
    dado_escrita = '0;
    reset_n      = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_dado_leitura", 32'(dado_leitura), 32'd0);
    chk("reset_leituras", 32'(leituras), 32'd0);
    chk("reset_escritas", 32'(escritas), 32'd0);

    // Read of an untouched address returns its reset pattern.
    do_read(5'd5);
    chk("read5_value", 32'(dado_leitura), 32'd5);

    // Write then read back.
    do_write(5'd3, 5'h1A);
    do_read(5'd3);
    chk("wr_rd_3", 32'(dado_leitura), 32'h1A);

    // Simultaneous requests: write first, then the still-held read.
    endereco     = 5'd9;
    dado_escrita = 5'h07;
    wr           = 1'b1;
    rd           = 1'b1;
    wait_done(1'b1, 5'd9, 5'h07, 1'b0);
    wait_done(1'b0, 5'd9, 5'h00, 1'b0);
    chk("both_rd_9", 32'(dado_leitura), 32'h07);

    // Inputs changing after acceptance must not affect the transaction.
    endereco     = 5'd12;
    dado_escrita = 5'h15;
    wr           = 1'b1;
    wait_done(1'b1, 5'd12, 5'h15, 1'b1);
    do_read(5'd12);
    chk("latched_wr_12", 32'(dado_leitura), 32'h15);
    do_read(~5'd12);
    endereco = 5'd6;
    rd       = 1'b1;
    wait_done(1'b0, 5'd6, 5'd0, 1'b1);

    // Random mixed traffic.
    for (int i = 0; i < 30; i++) begin
      ra   = 5'($urandom_range(0, 31));
      rdat = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) do_write(ra, rdat);
      else do_read(ra);
    end

    // Reset during BUSY of a write: abandoned, no done, memory reinitialised.
    endereco     = 5'd2;
    dado_escrita = 5'h1F;
    wr           = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    wr      = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n  = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done !== 1'b0) saw_done = 1;
    end
    chk("rst_mid_no_done", 32'(saw_done), 32'd0);
    chk("rst_mid_leituras", 32'(leituras), 32'd0);
    chk("rst_mid_escritas", 32'(escritas), 32'd0);
    do_read(5'd2);
    chk("rst_mid_mem2", 32'(dado_leitura), 32'd2);

    // Saturation of the read counter.
    for (int i = 0; i < 260; i++) do_read(5'($urandom_range(0, 31)));
    chk("leituras_saturated", 32'(leituras), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
